// File: rtl/shift_register_word_loader_pkg.sv
// Shared types and constants for the shift register word loader.
package shift_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_register_word_loader_bit_counter.sv
// Bit position counter for the word loader: clears on demand, steps once per
// shifted bit and flags the final bit position.
module shift_bit_counter #(
  parameter int MSB = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     step,
  output logic [$clog2(MSB)-1:0]   count,
  output logic                     last
);

  localparam int CW = $clog2(MSB);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(MSB - 1));

endmodule

// File: rtl/shift_register_word_loader.sv
// Word-level loader that serializes one parallel word onto a bidirectional
// shift register. Optional stall input enabled by macro LOADER_HOLD_EN.
module shift_register_word_loader #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
`ifdef LOADER_HOLD_EN
  input  logic           hold,
`endif
  output logic           indata,
  output logic           enable,
  output logic           direction,
  output logic           busy,
  output logic           done
);

  import shift_loader_pkg::*;

  localparam int CW = $clog2(MSB);

  state_t         state_q, state_d;
  logic [MSB-1:0] word_q, word_d;
  logic           dir_q, dir_d;
  logic           in_ready_q, in_ready_d;
  logic           enable_q, enable_d;
  logic           indata_q, indata_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           cnt_clear;
  logic           cnt_step;
  logic [CW-1:0]  count;
  logic           last;
  logic [CW-1:0]  next_idx;
  logic [CW-1:0]  rev_idx;
  logic           next_bit;
  logic           hold_w;

`ifdef LOADER_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  shift_bit_counter #(.MSB(MSB)) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .step   (cnt_step),
    .count  (count),
    .last   (last)
  );

  // Outputs are registered one cycle ahead, so the bit selected here is the
  // one that will be on indata during the next cycle.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    dir_d      = dir_q;
    in_ready_d = in_ready_q;
    enable_d   = 1'b0;
    indata_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_step   = 1'b0;
    next_idx   = enable_q ? (count + CW'(1)) : count;
    rev_idx    = CW'(MSB - 1) - next_idx;
    next_bit   = (dir_q == DIR_RIGHT) ? word_q[next_idx] : word_q[rev_idx];

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (in_valid && in_ready_q) begin
          state_d    = SHIFT;
          word_d     = in_data;
          dir_d      = in_dir;
          cnt_clear  = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          enable_d   = 1'b1;
          indata_d   = (in_dir == DIR_LEFT) ? in_data[MSB-1] : in_data[0];
        end
      end
      SHIFT: begin
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        if (enable_q && last) begin
          state_d   = DONE;
          done_d    = 1'b1;
          cnt_clear = 1'b1;
        end else begin
          cnt_step = enable_q;
          if (!hold_w) begin
            enable_d = 1'b1;
            indata_d = next_bit;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      word_q     <= '0;
      dir_q      <= 1'b0;
      in_ready_q <= 1'b1;
      enable_q   <= 1'b0;
      indata_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      dir_q      <= dir_d;
      in_ready_q <= in_ready_d;
      enable_q   <= enable_d;
      indata_q   <= indata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign enable    = enable_q;
  assign indata    = indata_q;
  assign direction = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_register_word_loader.sv
// Self-checking bench for shift_register_word_loader with a behavioural
// downstream register and a spec-level model of the serial bit order.
module tb_shift_register_word_loader;

  logic       clk;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic       indata;
  logic       enable;
  logic       direction;
  logic       busy;
  logic       done;
`ifdef LOADER_HOLD_EN
  logic       hold;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] dsreg = 8'h00;

  shift_register_word_loader #(.MSB(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
`ifdef LOADER_HOLD_EN
    .hold      (hold),
`endif
    .indata    (indata),
    .enable    (enable),
    .direction (direction),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream bidirectional shift register: dir 0 enters at LSB, dir 1 at MSB.
  always @(posedge clk) begin
    if (enable) begin
      if (direction) dsreg <= {indata, dsreg[7:1]};
      else           dsreg <= {dsreg[6:0], indata};
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic dir);
    in_valid = v;
    in_data  = d;
    in_dir   = dir;
  endtask

  // Serial order from the rules: dir 0 sends word MSB first, dir 1 LSB first.
  function automatic logic [7:0] modelSeq(input logic [7:0] w, input logic dir);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = dir ? w[i] : w[7-i];
    return s;
  endfunction

  // Called #1 after a posedge with the DUT idle; returns in cycle A+10(+holds).
  task automatic runWord(input logic [7:0] w, input logic dir, input logic [7:0] expSeq,
                         input bit keepValid, input int holdStart, input int holdLen);
    int enCount = 0;
    int doneCyc = -1;
    int readyCyc = -1;
    int badBits = 0;
    int badDir = 0;
    int badIdle = 0;
    int badBusy = 0;
    logic [7:0] dsAtDone = 8'h00;
    checkOutput("ready_before_load", in_ready, 1);
    applyStimulus(1'b1, w, dir);
    @(posedge clk); #1;
    if (!keepValid) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      if (keepValid) applyStimulus(1'b1, 8'($urandom), 1'($urandom));
`ifdef LOADER_HOLD_EN
      hold = (c >= holdStart) && (c < holdStart + holdLen);
`endif
      if (enable) begin
        if (enCount < 8 && indata !== expSeq[7-enCount]) badBits++;
        if (direction !== dir) badDir++;
        enCount++;
      end else if (indata !== 1'b0) begin
        badIdle++;
      end
      if (busy !== (c <= 9 + holdLen)) badBusy++;
      if (done && doneCyc < 0) begin
        doneCyc  = c;
        dsAtDone = dsreg;
      end
      if (in_ready) begin
        readyCyc = c;
        break;
      end
      @(posedge clk); #1;
    end
`ifdef LOADER_HOLD_EN
    hold = 1'b0;
`endif
    checkOutput("bit_order", badBits, 0);
    checkOutput("direction_held", badDir, 0);
    checkOutput("indata_zero_when_idle", badIdle, 0);
    checkOutput("busy_window", badBusy, 0);
    checkOutput("enable_cycles", enCount, 8);
    checkOutput("done_cycle", doneCyc, 9 + holdLen);
    checkOutput("ready_cycle", readyCyc, 10 + holdLen);
    checkOutput("outdata", dsAtDone, w);
  endtask

  initial begin
    int doneSeen;
    logic [7:0] rw;
    logic       rd;

    vecs[0] = '{8'hA5, 1'b0, 8'b10100101};
    vecs[1] = '{8'h3C, 1'b1, 8'b00111100};
    vecs[2] = '{8'hFF, 1'b0, 8'b11111111};
    vecs[3] = '{8'h01, 1'b1, 8'b10000000};
    vecs[4] = '{8'h80, 1'b0, 8'b10000000};
    vecs[5] = '{8'h6E, 1'b1, 8'b01110110};

    resetn = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
`ifdef LOADER_HOLD_EN
    hold = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_enable", enable, 0);
    checkOutput("reset_indata", indata, 0);
    checkOutput("reset_direction", direction, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      runWord(vecs[i].data, vecs[i].dir, vecs[i].seq, 1'b0, 0, 0);

    // Back-pressure: valid held with noisy data during SHIFT, then next word at A+10.
    runWord(8'hC3, 1'b0, 8'b11000011, 1'b1, 0, 0);
    runWord(8'h5A, 1'b1, 8'b01011010, 1'b0, 0, 0);

    // Back-to-back pair.
    runWord(8'h01, 1'b0, 8'b00000001, 1'b1, 0, 0);
    runWord(8'h80, 1'b0, 8'b10000000, 1'b0, 0, 0);

    // Reset asserted during the fourth enable cycle.
    applyStimulus(1'b1, 8'h5A, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("enable_before_reset", enable, 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset_enable", enable, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_indata", indata, 0);
    checkOutput("midreset_busy", busy, 0);
    resetn = 1'b1;
    doneSeen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    checkOutput("no_done_after_reset", doneSeen, 0);
    runWord(8'hFF, 1'b0, 8'b11111111, 1'b0, 0, 0);

`ifdef LOADER_HOLD_EN
    runWord(8'hA5, 1'b0, 8'b10100101, 1'b0, 3, 2);
`endif

    // Randomized words checked against the spec-level order model.
    for (int i = 0; i < 10; i++) begin
      rw = 8'($urandom);
      rd = 1'($urandom);
      runWord(rw, rd, modelSeq(rw, rd), 1'($urandom_range(0, 1)), 0, 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_register_word_loader.md
Name: shift_register_word_loader

Overview:
- Upstream feeder for the N-bit bidirectional shift register.
- Accepts one parallel word per valid/ready handshake and serializes it onto the register's indata/enable/direction inputs.
- Bit order is chosen so that after MSB shift cycles the downstream register's outdata equals the accepted word exactly.
- Pulses done when the word has fully landed; gives the register a clean word-level load interface.

Parameters:
- MSB, 8: word width in bits; matches the downstream register's MSB; legal range 2 and up.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream offers in_data/in_dir.
- in_ready  output  1  loader can accept a word; high only in IDLE.
- in_data  input  MSB  parallel word to load.
- in_dir  input  1  0 = shift left (LSB entry), 1 = shift right (MSB entry).
- indata  output  1  serial bit to register indata.
- enable  output  1  to register enable; high only while shifting.
- direction  output  1  to register direction; held for the whole word.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last bit is shifted.

Behaviour:
- Reset (async, resetn=0): state=IDLE, in_ready=1, enable=0, indata=0, direction=0, busy=0, done=0, word and count registers=0.
- All outputs come from registers or state decode only; there is no combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture in_data into the word register and in_dir into the direction register; count=0; go to SHIFT.
- SHIFT:
  - enable=1; direction=captured dir.
  - indata=word[MSB-1-count] when dir=0 (MSB first); indata=word[count] when dir=1 (LSB first).
  - count increments each edge. At count==MSB-1, go to DONE.
  - Exactly MSB enable-high cycles per word.
- DONE: enable=0, done=1 for exactly one cycle, then go to IDLE.
- Timing: handshake at cycle A; enable high in cycles A+1..A+MSB; downstream outdata equals the word after the edge ending cycle A+MSB; done high in cycle A+MSB+1; in_ready high again from cycle A+MSB+2.
- Throughput: one word per MSB+2 cycles.
- in_valid outside IDLE is ignored, with no capture. in_data/in_dir changing after capture has no effect.
- Counter width is $clog2(MSB); it never exceeds MSB-1.
- Reset asserted mid-word: enable drops immediately (async), the partial word is abandoned, and done is not pulsed. The downstream register's contents are not the loader's responsibility.
- indata is 0 whenever enable=0.

Optional Feature:
- Macro: LOADER_HOLD_EN.
- With the macro defined:
  - Adds input port hold (1 bit).
  - hold=1 in SHIFT forces enable=0 and freezes count and indata for that cycle.
  - hold has no effect in IDLE or DONE.
  - Total enable-high cycles stay exactly MSB; done is delayed by the number of held cycles.
- Without the macro: the port is absent and SHIFT never stalls.

Decomposition:
- Package shift_loader_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
- One sub-module is natural: shift_bit_counter (parameter MSB; inputs clk, resetn, clear, step; outputs count and last).
- FSM and bit-select stay in the top.

Test Plan:
- MSB=8, in_data=8'hA5, in_dir=0:
  - indata sequence 1,0,1,0,0,1,0,1 over 8 enable cycles;
  - downstream outdata=8'hA5;
  - done in cycle A+9; in_ready back in cycle A+10.
- in_data=8'h3C, in_dir=1:
  - indata sequence 0,0,1,1,1,1,0,0 (LSB first), direction=1 throughout;
  - downstream outdata=8'h3C.
- Back-pressure:
  - hold in_valid=1 with in_data changing every cycle during SHIFT;
  - in_ready=0 and no recapture; the loaded word is the one captured at handshake;
  - the next word is accepted only at cycle A+10.
- Reset mid-shift: assert resetn=0 after 3 enable cycles → enable=0 and in_ready=1 in the same cycle, no done pulse, and a clean reload of 8'hFF afterwards.
- Back-to-back: in_valid held high with 8'h01 then 8'h80 (dir 0) → two done pulses 10 cycles apart, outdata sequence 8'h01 then 8'h80.
- LOADER_HOLD_EN: hold=1 for 2 cycles mid-word on 8'hA5 → exactly 8 enable-high cycles, done at A+11, outdata=8'hA5.
